// File: rtl/diagv2_data_bridge.sv
// Data-side bridge from the core memory stage to N_REGIONS memory-mapped targets:
// region decode, alignment check, per-region wait states, core stall, load extension.
module diagv2_data_bridge #(
    parameter int                     XLEN         = 64,
    parameter int                     N_REGIONS    = 2,
    parameter int                     REGION_SHIFT = 28,
    parameter logic [N_REGIONS*4-1:0] WAIT_STATES  = {N_REGIONS{4'd0}}
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      req_valid,
    input  logic                      req_write,
    input  logic [2:0]                req_type,
    input  logic [XLEN-1:0]           req_addr,
    input  logic [XLEN-1:0]           req_wdata,
    output logic                      stall,
    output logic                      rsp_valid,
    output logic [XLEN-1:0]           rsp_rdata,
    output logic                      rsp_err,
    output logic [N_REGIONS-1:0]      tgt_sel,
    output logic                      tgt_we,
    output logic [2:0]                tgt_type,
    output logic [XLEN-1:0]           tgt_addr,
    output logic [XLEN-1:0]           tgt_wdata,
    input  logic [N_REGIONS*XLEN-1:0] tgt_rdata
);
    localparam int IDXW = (N_REGIONS > 1) ? $clog2(N_REGIONS) : 1;

    typedef enum logic [1:0] {IDLE, ACCESS, ERR} state_e;

    state_e                state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [N_REGIONS-1:0]  sel_q, sel_d;
    logic                  we_q, we_d;
    logic [2:0]            type_q, type_d;
    logic [XLEN-1:0]       addr_q, addr_d;
    logic [XLEN-1:0]       wdata_q, wdata_d;
    logic [XLEN-1:0]       rdata_q, rdata_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic                  rsp_err_q, rsp_err_d;

    logic [IDXW-1:0]       idx;
    logic                  dec_err, align_err, type_err, req_err;
    logic [XLEN-1:0]       raw, ext;
    logic                  stall_raw, we_raw;

    assign idx       = req_addr[REGION_SHIFT +: IDXW];
    assign dec_err   = int'(idx) >= N_REGIONS;
    assign align_err = (req_type[1:0] == 2'b01 && req_addr[0])
                    || (req_type[1:0] == 2'b10 && |req_addr[1:0])
                    || (req_type[1:0] == 2'b11 && |req_addr[2:0]);
    // Doubleword types do not exist on a 32-bit core.
    assign type_err  = (req_type == 3'b111)
                    || ((XLEN == 32) && (req_type == 3'b011 || req_type == 3'b110));
    assign req_err   = dec_err || align_err || type_err;

    always_comb begin
        raw = '0;
        for (int i = 0; i < N_REGIONS; i++) begin
            if (sel_q[i]) raw = raw | tgt_rdata[i*XLEN +: XLEN];
        end
    end

    always_comb begin
        case (type_q)
            3'b000:  ext = XLEN'(signed'(raw[7:0]));
            3'b001:  ext = XLEN'(signed'(raw[15:0]));
            3'b010:  ext = XLEN'(signed'(raw[31:0]));
            3'b011:  ext = raw;
            3'b100:  ext = XLEN'(raw[7:0]);
            3'b101:  ext = XLEN'(raw[15:0]);
            3'b110:  ext = XLEN'(raw[31:0]);
            default: ext = '0;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        sel_d       = sel_q;
        we_d        = we_q;
        type_d      = type_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        rdata_d     = '0;
        rsp_valid_d = 1'b0;
        rsp_err_d   = 1'b0;
        stall_raw   = 1'b0;
        we_raw      = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    stall_raw = 1'b1;
                    if (req_err) begin
                        state_d = ERR;
                    end else begin
                        sel_d   = N_REGIONS'(1) << idx;
                        we_d    = req_write;
                        type_d  = req_type;
                        addr_d  = req_addr;
                        wdata_d = req_wdata;
                        cnt_d   = WAIT_STATES[4*idx +: 4];
                        state_d = ACCESS;
                    end
                end
            end
            ACCESS: begin
                stall_raw = 1'b1;
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    we_raw      = we_q;
                    rsp_valid_d = 1'b1;
                    rdata_d     = we_q ? '0 : ext;
                    sel_d       = '0;
                    state_d     = IDLE;
                end
            end
            ERR: begin
                stall_raw   = 1'b1;
                rsp_valid_d = 1'b1;
                rsp_err_d   = 1'b1;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            sel_q       <= '0;
            we_q        <= 1'b0;
            type_q      <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rdata_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            sel_q       <= sel_d;
            we_q        <= we_d;
            type_q      <= type_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rdata_q     <= rdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    // Reset forces the combinational outputs low too, so an aborted access never strobes.
    assign stall     = stall_raw & ~reset;
    assign tgt_we    = we_raw & ~reset;
    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_rdata = rdata_q;
    assign tgt_sel   = sel_q;
    assign tgt_type  = type_q;
    assign tgt_addr  = addr_q;
    assign tgt_wdata = wdata_q;

endmodule

// File: tb/tb_diagv2_data_bridge.sv
// Self-checking bench for diagv2_data_bridge: directed vector table, reset/back-to-back
// sequences and random accesses scored against a behavioural memory model.
module tb_diagv2_data_bridge;
    logic         clk = 1'b0;
    logic         reset;
    logic         req_valid, req_write;
    logic [2:0]   req_type;
    logic [63:0]  req_addr, req_wdata;
    logic         stall, rsp_valid, rsp_err;
    logic [63:0]  rsp_rdata;
    logic [1:0]   tgt_sel;
    logic         tgt_we;
    logic [2:0]   tgt_type;
    logic [63:0]  tgt_addr, tgt_wdata;
    logic [127:0] tgt_rdata;

    logic         stall3, rsp_valid3, rsp_err3, tgt_we3;
    logic [63:0]  rsp_rdata3, tgt_addr3, tgt_wdata3;
    logic [2:0]   tgt_sel3, tgt_type3;
    logic [191:0] tgt_rdata3;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    diagv2_data_bridge #(.XLEN(64), .N_REGIONS(2), .REGION_SHIFT(28), .WAIT_STATES(8'h30)) u_dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_write(req_write),
        .req_type(req_type), .req_addr(req_addr), .req_wdata(req_wdata),
        .stall(stall), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .tgt_sel(tgt_sel), .tgt_we(tgt_we), .tgt_type(tgt_type), .tgt_addr(tgt_addr),
        .tgt_wdata(tgt_wdata), .tgt_rdata(tgt_rdata));

    // Three-region instance: a two-bit index field makes index 3 a decode error.
    diagv2_data_bridge #(.XLEN(64), .N_REGIONS(3), .REGION_SHIFT(28), .WAIT_STATES(12'h030)) u_dut3 (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_write(req_write),
        .req_type(req_type), .req_addr(req_addr), .req_wdata(req_wdata),
        .stall(stall3), .rsp_valid(rsp_valid3), .rsp_rdata(rsp_rdata3), .rsp_err(rsp_err3),
        .tgt_sel(tgt_sel3), .tgt_we(tgt_we3), .tgt_type(tgt_type3), .tgt_addr(tgt_addr3),
        .tgt_wdata(tgt_wdata3), .tgt_rdata(tgt_rdata3));
    assign tgt_rdata3 = '0;

    // Target model: one 64-bit right-aligned slot per low address byte, per region.
    logic [63:0] mem0 [256];
    logic [63:0] mem1 [256];
    logic        pl_en = 1'b0;
    logic [7:0]  pl_a;
    logic [63:0] pl_d0, pl_d1;

    always @(posedge clk) begin
        if (pl_en) begin
            mem0[pl_a] <= pl_d0;
            mem1[pl_a] <= pl_d1;
        end else if (tgt_we) begin
            if (tgt_sel[1]) mem1[tgt_addr[7:0]] <= tgt_wdata;
            else if (tgt_sel[0]) mem0[tgt_addr[7:0]] <= tgt_wdata;
        end
    end
    assign tgt_rdata = {mem1[tgt_addr[7:0]], mem0[tgt_addr[7:0]]};

    logic [63:0] ref_mem [2][256];
    int ws [2] = '{0, 3};

    typedef struct {
        logic        wr;
        logic [2:0]  ty;
        logic [63:0] addr;
        logic [63:0] wd;
        logic        err;
        logic [63:0] data;
        int          lat;
    } vec_t;
    vec_t tbl [14];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic void model(input logic wr, input logic [2:0] ty, input logic [63:0] addr,
                                  output logic err, output logic [63:0] data, output int lat);
        int rg, n;
        logic [63:0] raw;
        rg   = int'((addr >> 28) % 64'd2);
        n    = 1 << (ty % 4);
        err  = (ty == 3'd7) || (addr % n != 0);
        lat  = err ? 2 : ws[rg] + 2;
        raw  = ref_mem[rg][int'(addr % 256)];
        data = 64'd0;
        if (!err && !wr) begin
            data = raw;
            if (n < 8) begin
                data = raw & ((64'd1 << (8*n)) - 64'd1);
                if (ty < 4 && data[8*n-1]) data = data - (64'd1 << (8*n));
            end
        end
    endfunction

    // Called at posedge+1; returns at posedge+1 of the response cycle with req_valid low.
    task automatic access(input logic wr, input logic [2:0] ty, input logic [63:0] addr,
                          input logic [63:0] wd, input logic e_err, input logic [63:0] e_data,
                          input int e_lat);
        int rg, cyc, we_cnt;
        logic stall_ok, sel_ok, wd_ok;
        logic [1:0] exp_sel;
        rg = int'((addr >> 28) % 64'd2);
        req_valid = 1'b1; req_write = wr; req_type = ty; req_addr = addr; req_wdata = wd;
        cyc = 0; we_cnt = 0; stall_ok = 1'b1; sel_ok = 1'b1; wd_ok = 1'b1;
        while (1) begin
            @(negedge clk);
            if (!stall) stall_ok = 1'b0;
            exp_sel = (e_err || cyc == 0) ? 2'b00 : 2'(1 << rg);
            if (tgt_sel !== exp_sel) sel_ok = 1'b0;
            if (tgt_we) begin
                we_cnt++;
                if (tgt_wdata !== wd || tgt_addr !== addr || tgt_type !== ty) wd_ok = 1'b0;
            end
            @(posedge clk); #1;
            cyc++;
            if (rsp_valid || cyc > 40) break;
        end
        req_valid = 1'b0;
        chk("latency", 64'(cyc), 64'(e_lat));
        chk("rsp_err", 64'(rsp_err), 64'(e_err));
        chk("rsp_rdata", rsp_rdata, e_data);
        chk("stall_held", 64'(stall_ok), 64'd1);
        chk("tgt_sel", 64'(sel_ok), 64'd1);
        chk("tgt_we_pulses", 64'(we_cnt), 64'((wr && !e_err) ? 1 : 0));
        chk("tgt_write_fields", 64'(wd_ok), 64'd1);
        if (wr && !e_err) ref_mem[rg][int'(addr % 256)] = wd;
    endtask

    initial begin
        logic stall_seen, we_seen, rsp_seen, sel_seen;
        logic m_err;
        logic [63:0] m_data, a;
        int m_lat, waited;

        reset = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_type = '0;
        req_addr = '0; req_wdata = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_stall", 64'(stall), 64'd0);
        chk("reset_rsp", 64'({rsp_valid, rsp_err}), 64'd0);
        chk("reset_rdata", rsp_rdata, 64'd0);
        chk("reset_tgt", 64'(|{tgt_sel, tgt_we, tgt_type, tgt_addr, tgt_wdata}), 64'd0);
        chk("reset_u3", 64'(|{stall3, rsp_valid3, rsp_err3, rsp_rdata3, tgt_sel3, tgt_we3,
                              tgt_type3, tgt_addr3, tgt_wdata3}), 64'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        for (int i = 0; i < 256; i++) begin
            pl_en = 1'b1; pl_a = 8'(i);
            pl_d0 = {$urandom, $urandom}; pl_d1 = {$urandom, $urandom};
            if (i == 8'h10) pl_d0 = 64'h0000_0000_8000_0001;
            if (i == 8'h20) pl_d1 = 64'h0000_0000_0000_00AB;
            ref_mem[0][i] = pl_d0; ref_mem[1][i] = pl_d1;
            @(posedge clk); #1;
        end
        pl_en = 1'b0;

        // Reset held three cycles in the middle of a W=3 access.
        req_valid = 1'b1; req_write = 1'b1; req_type = 3'b011;
        req_addr = 64'h1000_0018; req_wdata = 64'hDEAD_BEEF_0BAD_F00D;
        @(posedge clk); #1;
        reset = 1'b1;
        stall_seen = 1'b0; we_seen = 1'b0; rsp_seen = 1'b0; sel_seen = 1'b0;
        repeat (3) begin
            @(negedge clk);
            stall_seen |= stall; we_seen |= tgt_we; rsp_seen |= rsp_valid;
            @(posedge clk); #1;
            sel_seen |= (tgt_sel != 2'b00);
        end
        reset = 1'b0; req_valid = 1'b0;
        repeat (6) begin
            @(negedge clk);
            we_seen |= tgt_we; rsp_seen |= rsp_valid; sel_seen |= (tgt_sel != 2'b00);
            @(posedge clk); #1;
        end
        chk("abort_stall", 64'(stall_seen), 64'd0);
        chk("abort_tgt_we", 64'(we_seen), 64'd0);
        chk("abort_rsp_valid", 64'(rsp_seen), 64'd0);
        chk("abort_tgt_sel", 64'(sel_seen), 64'd0);
        chk("abort_no_write", mem1[8'h18], ref_mem[1][8'h18]);

        tbl[0]  = '{1'b0, 3'b010, 64'h0000_0010, 64'h0, 1'b0, 64'hFFFF_FFFF_8000_0001, 2};
        tbl[1]  = '{1'b0, 3'b100, 64'h1000_0020, 64'h0, 1'b0, 64'h0000_0000_0000_00AB, 5};
        tbl[2]  = '{1'b0, 3'b000, 64'h1000_0020, 64'h0, 1'b0, 64'hFFFF_FFFF_FFFF_FFAB, 5};
        tbl[3]  = '{1'b1, 3'b011, 64'h1000_0008, 64'h1122_3344_5566_7788, 1'b0, 64'h0, 5};
        tbl[4]  = '{1'b0, 3'b011, 64'h1000_0008, 64'h0, 1'b0, 64'h1122_3344_5566_7788, 5};
        tbl[5]  = '{1'b0, 3'b001, 64'h0000_0003, 64'h0, 1'b1, 64'h0, 2};
        tbl[6]  = '{1'b0, 3'b011, 64'h0000_0004, 64'h0, 1'b1, 64'h0, 2};
        tbl[7]  = '{1'b0, 3'b111, 64'h0000_0000, 64'h0, 1'b1, 64'h0, 2};
        tbl[8]  = '{1'b0, 3'b101, 64'h0000_0010, 64'h0, 1'b0, 64'h0000_0000_0000_0001, 2};
        tbl[9]  = '{1'b0, 3'b110, 64'h0000_0010, 64'h0, 1'b0, 64'h0000_0000_8000_0001, 2};
        tbl[10] = '{1'b1, 3'b000, 64'h1000_0031, 64'hFFFF_FFFF_FFFF_FF5A, 1'b0, 64'h0, 5};
        tbl[11] = '{1'b0, 3'b000, 64'h1000_0031, 64'h0, 1'b0, 64'h0000_0000_0000_005A, 5};
        tbl[12] = '{1'b1, 3'b001, 64'h1000_0001, 64'h1234, 1'b1, 64'h0, 2};
        tbl[13] = '{1'b0, 3'b001, 64'h1000_0020, 64'h0, 1'b0, 64'h0000_0000_0000_00AB, 5};
        foreach (tbl[i]) begin
            access(tbl[i].wr, tbl[i].ty, tbl[i].addr, tbl[i].wd, tbl[i].err, tbl[i].data, tbl[i].lat);
            @(negedge clk);
            chk("idle_stall", 64'(stall), 64'd0);
            @(posedge clk); #1;
            chk("rsp_one_pulse", 64'(rsp_valid), 64'd0);
        end

        // Back-to-back: the load is issued in the store's response cycle.
        access(1'b1, 3'b010, 64'h0000_0040, 64'h0000_0000_1234_5678, 1'b0, 64'h0, 2);
        access(1'b0, 3'b010, 64'h0000_0040, 64'h0, 1'b0, 64'h0000_0000_1234_5678, 2);
        @(negedge clk);
        chk("b2b_idle_stall", 64'(stall), 64'd0);
        @(posedge clk); #1;

        // Region index 3 on the three-region instance is a decode error.
        req_valid = 1'b1; req_write = 1'b0; req_type = 3'b000; req_addr = 64'h3000_0000;
        @(negedge clk);
        chk("dec_stall", 64'(stall3), 64'd1);
        sel_seen = (tgt_sel3 != 3'b000);
        @(posedge clk); #1;
        chk("dec_no_early_rsp", 64'(rsp_valid3), 64'd0);
        @(negedge clk);
        sel_seen |= (tgt_sel3 != 3'b000) || tgt_we3;
        @(posedge clk); #1;
        chk("dec_rsp_valid", 64'(rsp_valid3), 64'd1);
        chk("dec_rsp_err", 64'(rsp_err3), 64'd1);
        chk("dec_rsp_rdata", rsp_rdata3, 64'd0);
        chk("dec_no_target", 64'(sel_seen), 64'd0);
        waited = 0;
        while (!rsp_valid && waited < 20) begin
            @(posedge clk); #1;
            waited++;
        end
        req_valid = 1'b0;
        chk("dec_primary_done", 64'(rsp_valid), 64'd1);
        repeat (3) @(posedge clk);
        #1;

        for (int n = 0; n < 150; n++) begin
            logic wr;
            logic [2:0] ty;
            wr = 1'($urandom_range(0, 1));
            ty = 3'($urandom_range(0, 7));
            a  = (64'($urandom_range(0, 1)) << 28) | (64'($urandom_range(0, 4095)) << 8);
            a |= 64'($urandom_range(0, 3) == 0 ? $urandom_range(0, 255) : $urandom_range(0, 31) * 8);
            model(wr, ty, a, m_err, m_data, m_lat);
            access(wr, ty, a, {$urandom, $urandom}, m_err, m_data, m_lat);
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk); #1;
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
